// File: rtl/fifo_row_arbiter_if.sv
// Handshake bundle between requesters, the FIFO row datapath and the response consumer.
// slave = arbiter view, master = environment (requesters, FIFO row, consumer).
interface fifo_row_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      fifo_en;
   logic [DATA_W-1:0]         fifo_data_in;
   logic [DATA_W-1:0]         fifo_data_out;
   logic                      rsp_valid;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_data;

   modport slave (
      input  req_valid, req_data, fifo_data_out,
      output req_ready, fifo_en, fifo_data_in, rsp_valid, rsp_id, rsp_data
   );

   modport master (
      output req_valid, req_data, fifo_data_out,
      input  req_ready, fifo_en, fifo_data_in, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/fifo_row_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FIFO row between NUM_REQ requesters,
// tagging each issued sample so its FIFO output returns to the originating requester.
module fifo_row_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 4,
   parameter int LATENCY = 2,
   parameter int ID_W    = 2
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_arb_en,
   input  logic                i_flush,
   fifo_row_arbiter_if.slave   bus,
   output logic                o_busy,
   output logic [1:0]          o_state
);
   localparam int CNT_W = $clog2(LATENCY + 3);

   typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, DRAIN = 2'd2} state_t;

   state_t                       r_state;
   logic [ID_W-1:0]              r_ptr;
   // stage 0 is the issue register itself (it drives fifo_en); stage LATENCY lines up with fifo_data_out
   logic [LATENCY:0]             r_vld_pipe;
   logic [LATENCY:0][ID_W-1:0]   r_id_pipe;
   logic [DATA_W-1:0]            r_fifo_data;
   logic                         r_rsp_valid;
   logic [ID_W-1:0]              r_rsp_id;
   logic [DATA_W-1:0]            r_rsp_data;
   logic [CNT_W-1:0]             r_inflight;

   logic                         w_found;
   logic [NUM_REQ-1:0]           w_gnt;
   logic [ID_W-1:0]              w_gnt_id;
   logic [DATA_W-1:0]            w_sel_data;
   logic                         w_xfer;
   logic                         w_rsp;

   // first valid requester searching ptr, ptr+1, ... modulo NUM_REQ
   always_comb begin
      int idx;
      idx        = 0;
      w_found    = 1'b0;
      w_gnt      = '0;
      w_gnt_id   = '0;
      w_sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(r_ptr) + k) % NUM_REQ;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (i == idx && !w_found && bus.req_valid[i]) begin
               w_found    = 1'b1;
               w_gnt[i]   = 1'b1;
               w_gnt_id   = ID_W'(i);
               w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign w_xfer        = (r_state == ARB) && w_found;
   assign w_rsp         = r_vld_pipe[LATENCY];
   assign bus.req_ready = (r_state == ARB) ? w_gnt : '0;
   assign bus.fifo_en      = r_vld_pipe[0];
   assign bus.fifo_data_in = r_fifo_data;
   assign bus.rsp_valid    = r_rsp_valid;
   assign bus.rsp_id       = r_rsp_id;
   assign bus.rsp_data     = r_rsp_data;
   assign o_busy  = (r_state != IDLE) || (r_inflight != '0);
   assign o_state = r_state;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_vld_pipe  <= '0;
         r_id_pipe   <= '0;
         r_fifo_data <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_inflight  <= '0;
      end else begin
         case (r_state)
            IDLE:    if (i_arb_en && !i_flush) r_state <= ARB;
            ARB:     if (i_flush || !i_arb_en) r_state <= DRAIN;
            DRAIN:   if (r_inflight == '0 && !i_flush) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase

         if (w_xfer) begin
            r_ptr       <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
            r_fifo_data <= w_sel_data;
         end

         r_vld_pipe <= {r_vld_pipe[LATENCY-1:0], w_xfer};
         r_id_pipe  <= {r_id_pipe[LATENCY-1:0], w_gnt_id};

         r_rsp_valid <= w_rsp;
         if (w_rsp) begin
            r_rsp_id   <= r_id_pipe[LATENCY];
            r_rsp_data <= bus.fifo_data_out;
         end

         // a sample stops counting once its response is being registered
         case ({w_xfer, w_rsp})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   a_inflight_bound: assert property (@(posedge i_clk) disable iff (i_rst)
      r_inflight < CNT_W'(LATENCY + 2));

endmodule

// File: tb/tb_fifo_row_arbiter.sv
// Directed bench for fifo_row_arbiter: per-cycle vector table plus hand sequences
// for flush drain, reset with samples in flight, and arb_en drop.
module tb_fifo_row_arbiter;
   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 4;
   localparam int LATENCY = 2;
   localparam int ID_W    = 2;

   logic clk = 1'b0;
   logic rst, arb_en, flush, busy;
   logic [1:0] state;
   int checks = 0;
   int failures = 0;

   fifo_row_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

   fifo_row_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LATENCY(LATENCY), .ID_W(ID_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_arb_en(arb_en), .i_flush(flush),
      .bus(bus), .o_busy(busy), .o_state(state)
   );

   always #5 clk = ~clk;

   // FIFO row model: pure echo with LATENCY cycles of delay
   logic [LATENCY-1:0][DATA_W-1:0] fpipe;
   always_ff @(posedge clk) fpipe <= {fpipe[LATENCY-2:0], bus.fifo_data_in};
   assign bus.fifo_data_out = fpipe[LATENCY-1];

   typedef struct {
      logic rst, en, fl;
      logic [3:0] v;
      logic [15:0] d;
      logic [3:0] rdy;
      logic fen;
      logic [3:0] fd;
      logic rv;
      logic [1:0] rid;
      logic [3:0] rd;
      logic [1:0] st;
      logic bsy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic e, logic f, logic [3:0] v, logic [15:0] d,
                               logic [3:0] rdy, logic fen, logic [3:0] fd,
                               logic rv, logic [1:0] rid, logic [3:0] rd, logic [1:0] st, logic b);
      vec_t x;
      x.rst = r; x.en = e; x.fl = f; x.v = v; x.d = d; x.rdy = rdy; x.fen = fen; x.fd = fd;
      x.rv = rv; x.rid = rid; x.rd = rd; x.st = st; x.bsy = b;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic e, input logic f, input logic [3:0] v,
                        input logic [15:0] d);
      rst = r; arb_en = e; flush = f; bus.req_valid = v; bus.req_data = d;
   endtask

   int got_id[$];
   int got_d[$];
   int last_rsp_cyc, idle_cyc;
   logic seen_rsp;

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      drive(1, 0, 0, 4'b0000, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", bus.req_ready, 0);
      chk("reset_fifo_en", bus.fifo_en, 0);
      chk("reset_fifo_din", bus.fifo_data_in, 0);
      chk("reset_rsp_valid", bus.rsp_valid, 0);
      chk("reset_rsp_id", bus.rsp_id, 0);
      chk("reset_rsp_data", bus.rsp_data, 0);
      chk("reset_state", state, 0);
      chk("reset_busy", busy, 0);

      // single transfer; then 0101 from ptr=1; then reset and all four from ptr=0
      tbl.push_back(mk(0,1,0,4'b0001,16'h000A, 4'b0000,0,4'h0, 0,0,4'h0, 0,0));
      tbl.push_back(mk(0,1,0,4'b0001,16'h000A, 4'b0001,0,4'h0, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h000A, 4'b0000,1,4'hA, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h000A, 4'b0000,0,4'h0, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h000A, 4'b0000,0,4'h0, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h000A, 4'b0000,0,4'h0, 1,0,4'hA, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h000A, 4'b0000,0,4'h0, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b0101,16'h4321, 4'b0100,0,4'h0, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b0101,16'h4321, 4'b0001,1,4'h3, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h4321, 4'b0000,1,4'h1, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h4321, 4'b0000,0,4'h0, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h4321, 4'b0000,0,4'h0, 1,2,4'h3, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h4321, 4'b0000,0,4'h0, 1,0,4'h1, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h4321, 4'b0000,0,4'h0, 0,0,4'h0, 1,1));
      tbl.push_back(mk(1,0,0,4'b0000,16'h4321, 4'b0000,0,4'h0, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b1111,16'h4321, 4'b0000,0,4'h0, 0,0,4'h0, 0,0));
      tbl.push_back(mk(0,1,0,4'b1111,16'h4321, 4'b0001,0,4'h0, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b1111,16'h4321, 4'b0010,1,4'h1, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b1111,16'h4321, 4'b0100,1,4'h2, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b1111,16'h4321, 4'b1000,1,4'h3, 0,0,4'h0, 1,1));
      tbl.push_back(mk(0,1,0,4'b1111,16'h4321, 4'b0001,1,4'h4, 1,0,4'h1, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h4321, 4'b0000,1,4'h1, 1,1,4'h2, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h4321, 4'b0000,0,4'h0, 1,2,4'h3, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h4321, 4'b0000,0,4'h0, 1,3,4'h4, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h4321, 4'b0000,0,4'h0, 1,0,4'h1, 1,1));
      tbl.push_back(mk(0,1,0,4'b0000,16'h4321, 4'b0000,0,4'h0, 0,0,4'h0, 1,1));

      foreach (tbl[n]) begin
         nxt();
         drive(tbl[n].rst, tbl[n].en, tbl[n].fl, tbl[n].v, tbl[n].d);
         @(negedge clk);
         chk($sformatf("v%0d_ready", n), bus.req_ready, tbl[n].rdy);
         chk($sformatf("v%0d_state", n), state, tbl[n].st);
         chk($sformatf("v%0d_busy", n), busy, tbl[n].bsy);
         chk($sformatf("v%0d_fifo_en", n), bus.fifo_en, tbl[n].fen);
         if (tbl[n].fen) chk($sformatf("v%0d_fifo_din", n), bus.fifo_data_in, tbl[n].fd);
         chk($sformatf("v%0d_rsp_valid", n), bus.rsp_valid, tbl[n].rv);
         if (tbl[n].rv) begin
            chk($sformatf("v%0d_rsp_id", n), bus.rsp_id, tbl[n].rid);
            chk($sformatf("v%0d_rsp_data", n), bus.rsp_data, tbl[n].rd);
         end
      end

      // flush after two back-to-back transfers (ptr=1)
      nxt(); drive(0, 1, 0, 4'b0011, 16'h4321); @(negedge clk);
      chk("fl_gnt_a", bus.req_ready, 4'b0010);
      nxt(); @(negedge clk);
      chk("fl_gnt_b", bus.req_ready, 4'b0001);
      nxt(); drive(0, 1, 1, 4'b0000, 16'h4321); @(negedge clk);
      chk("fl_state_arb", state, 1);
      chk("fl_din_b", bus.fifo_data_in, 4'h1);
      nxt(); drive(0, 0, 0, 4'b1111, 16'h4321); @(negedge clk);
      chk("fl_state_drain", state, 2);
      chk("fl_drain_ready", bus.req_ready, 0);
      chk("fl_drain_busy", busy, 1);
      got_id.delete(); got_d.delete();
      last_rsp_cyc = -1; idle_cyc = -1;
      for (int c = 1; c <= 12; c++) begin
         nxt(); @(negedge clk);
         if (bus.rsp_valid) begin
            got_id.push_back(int'(bus.rsp_id)); got_d.push_back(int'(bus.rsp_data));
            last_rsp_cyc = c;
         end
         if (state == 2'd0) begin
            idle_cyc = c;
            break;
         end
      end
      chk("fl_to_idle", state, 0);
      chk("fl_idle_busy", busy, 0);
      chk("fl_rsp_count", got_id.size(), 2);
      if (got_id.size() == 2) begin
         chk("fl_rsp0_id", got_id[0], 1); chk("fl_rsp0_d", got_d[0], 2);
         chk("fl_rsp1_id", got_id[1], 0); chk("fl_rsp1_d", got_d[1], 1);
      end
      chk("fl_idle_timing", idle_cyc, last_rsp_cyc + 1);

      // reset while two samples are in flight
      nxt(); drive(0, 1, 0, 4'b1111, 16'h4321);
      nxt(); nxt();
      nxt(); drive(1, 0, 0, 4'b0000, 16'h4321); @(negedge clk);
      chk("rs_inflight_fen", bus.fifo_en, 1);
      nxt(); drive(0, 0, 0, 4'b0000, 16'h4321); @(negedge clk);
      chk("rs_state", state, 0);
      chk("rs_busy", busy, 0);
      chk("rs_fifo_en", bus.fifo_en, 0);
      chk("rs_fifo_din", bus.fifo_data_in, 0);
      chk("rs_rsp_id", bus.rsp_id, 0);
      chk("rs_rsp_data", bus.rsp_data, 0);
      seen_rsp = bus.rsp_valid;
      for (int c = 0; c < 8; c++) begin
         nxt(); @(negedge clk);
         seen_rsp = seen_rsp | bus.rsp_valid;
      end
      chk("rs_no_rsp", seen_rsp, 0);
      chk("rs_busy_after", busy, 0);

      // arb_en dropped during back-to-back traffic (ptr=0 after reset)
      nxt(); drive(0, 1, 0, 4'b1111, 16'h4321); @(negedge clk);
      chk("en_idle", state, 0);
      nxt(); @(negedge clk);
      chk("en_gnt0", bus.req_ready, 4'b0001);
      nxt(); drive(0, 0, 0, 4'b1111, 16'h4321); @(negedge clk);
      chk("en_gnt1", bus.req_ready, 4'b0010);
      nxt(); @(negedge clk);
      chk("en_drain", state, 2);
      chk("en_no_grant", bus.req_ready, 0);
      chk("en_last_issue", bus.fifo_data_in, 4'h2);
      nxt(); @(negedge clk);
      chk("en_no_issue", bus.fifo_en, 0);
      got_id.delete(); got_d.delete();
      for (int c = 0; c < 12; c++) begin
         nxt(); @(negedge clk);
         if (bus.rsp_valid) begin
            got_id.push_back(int'(bus.rsp_id)); got_d.push_back(int'(bus.rsp_data));
         end
         if (state == 2'd0) break;
      end
      chk("en_final_state", state, 0);
      chk("en_final_busy", busy, 0);
      chk("en_rsp_count", got_id.size(), 2);
      if (got_id.size() == 2) begin
         chk("en_rsp0_id", got_id[0], 0); chk("en_rsp0_d", got_d[0], 1);
         chk("en_rsp1_id", got_id[1], 1); chk("en_rsp1_d", got_d[1], 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
